// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode classification for the sequential ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_SUB = 5'h01;
    localparam logic [4:0] OP_INC = 5'h02;
    localparam logic [4:0] OP_DEC = 5'h03;
    localparam logic [4:0] OP_AND = 5'h04;
    localparam logic [4:0] OP_OR  = 5'h05;
    localparam logic [4:0] OP_XOR = 5'h06;
    localparam logic [4:0] OP_NOT = 5'h07;
    localparam logic [4:0] OP_PASS = 5'h08;
    localparam logic [4:0] OP_SHL1 = 5'h09;
    localparam logic [4:0] OP_SHR1 = 5'h0A;
    localparam logic [4:0] OP_ROL1 = 5'h0B;
    localparam logic [4:0] OP_ROR1 = 5'h0C;
    localparam logic [4:0] OP_RCL = 5'h0D;
    localparam logic [4:0] OP_RCR = 5'h0E;
    localparam logic [4:0] OP_SHL = 5'h10;
    localparam logic [4:0] OP_SHR = 5'h11;
    localparam logic [4:0] OP_ROL = 5'h12;
    localparam logic [4:0] OP_ROR = 5'h13;
    localparam logic [4:0] OP_MUL = 5'h14;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic logic is_multi(input logic [4:0] sel);
        return (sel >= OP_SHL) && (sel <= OP_MUL);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU result and flags; multi-bit shifts here cover only the k=0 case.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [4:0]       select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             illegal
);

    logic [WIDTH-1:0] bb;
    logic             ci;
    logic [WIDTH:0]   sum;

    always_comb begin
        bb = '0;
        ci = 1'b0;
        case (select)
            OP_ADD: begin bb = b;  ci = cin; end
            OP_SUB: begin bb = ~b; ci = cin; end
            OP_INC: ci = 1'b1;
            OP_DEC: bb = '1;
            default: ;
        endcase
        sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};

        y       = '0;
        cout    = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (select)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                y    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_PASS: y = a;
            OP_SHL1: begin y = {a[WIDTH-2:0], 1'b0};        cout = a[WIDTH-1]; end
            OP_SHR1: begin y = {1'b0, a[WIDTH-1:1]};        cout = a[0];       end
            OP_ROL1: begin y = {a[WIDTH-2:0], a[WIDTH-1]};  cout = a[WIDTH-1]; end
            OP_ROR1: begin y = {a[0], a[WIDTH-1:1]};        cout = a[0];       end
            OP_RCL:  begin y = {a[WIDTH-2:0], cin};         cout = a[WIDTH-1]; end
            OP_RCR:  begin y = {cin, a[WIDTH-1:1]};         cout = a[0];       end
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: y = a;
            // MUL always goes through the sequential datapath
            OP_MUL: ;
            default: illegal = 1'b1;
        endcase
        zero = (y == '0) && !illegal;
        neg  = y[WIDTH-1];
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: registered results, multi-cycle shifts/rotates and shift-add multiply.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d, sh_q, sh_d, acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d, zero_q, zero_d, neg_q, neg_d;
    logic             ovf_q, ovf_d, ill_q, ill_d;

    logic [WIDTH-1:0] c_y;
    logic             c_cout, c_zero, c_neg, c_ovf, c_ill;
    logic [WIDTH-1:0] step_sh, mul_lo;
    logic             step_out;
    logic [WIDTH:0]   mul_sum;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .select (select),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .y      (c_y),
        .cout   (c_cout),
        .zero   (c_zero),
        .neg    (c_neg),
        .ovf    (c_ovf),
        .illegal(c_ill)
    );

    // One BUSY step: single-position shift/rotate, or add-and-shift of {acc, multiplier}
    always_comb begin
        step_sh  = sh_q;
        step_out = 1'b0;
        case (op_q)
            OP_SHL: begin step_sh = {sh_q[WIDTH-2:0], 1'b0};          step_out = sh_q[WIDTH-1]; end
            OP_SHR: begin step_sh = {1'b0, sh_q[WIDTH-1:1]};          step_out = sh_q[0];       end
            OP_ROL: begin step_sh = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]}; step_out = sh_q[WIDTH-1]; end
            OP_ROR: begin step_sh = {sh_q[0], sh_q[WIDTH-1:1]};       step_out = sh_q[0];       end
            default: ;
        endcase
        mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
        mul_lo  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opa_d   = opa_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        y_d     = y_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d = select;
                if (select == OP_MUL) begin
                    opa_d   = a;
                    sh_d    = b;
                    acc_d   = '0;
                    cnt_d   = (SHW+1)'(WIDTH);
                    state_d = BUSY;
                end else if (is_multi(select) && (b[SHW-1:0] != '0)) begin
                    sh_d    = a;
                    cnt_d   = {1'b0, b[SHW-1:0]};
                    state_d = BUSY;
                end else begin
                    y_d     = c_y;
                    cout_d  = c_cout;
                    zero_d  = c_zero;
                    neg_d   = c_neg;
                    ovf_d   = c_ovf;
                    ill_d   = c_ill;
                    state_d = DONE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - (SHW+1)'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_sum[WIDTH:1];
                    sh_d  = mul_lo;
                end else begin
                    sh_d  = step_sh;
                end
                if (cnt_q == (SHW+1)'(1)) begin
                    y_d     = sh_d;
                    cout_d  = (op_q == OP_MUL) ? (acc_d != '0) : step_out;
                    zero_d  = (sh_d == '0);
                    neg_d   = sh_d[WIDTH-1];
                    ovf_d   = 1'b0;
                    ill_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

    // Working operands are only meaningful while BUSY, so they carry no reset
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        opa_q <= opa_d;
        sh_q  <= sh_d;
        acc_q <= acc_d;
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign illegal   = ill_q;

endmodule
